dm_lsu: RTL and testbench

Load/store unit sitting between the CPU datapath and the word-wide data memory. Accepts byte, halfword and word accesses at a byte address. Drives the memory's word address, write data and write-enable, and returns an aligned, sign- or zero-extended load result with a one-cycle acknowledge. Sub-word stores are performed as read-modify-write, because the memory only writes full words.

---
 rtl/dm_lsu_pkg.sv | 34 +++
 rtl/dm_lsu_if.sv | 30 +++
 rtl/dm_lsu_lane.sv | 53 +++++
 rtl/dm_lsu.sv | 89 ++++++++
 tb/tb_dm_lsu.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/dm_lsu_pkg.sv
// Shared types for the data-memory load/store unit.
// Holds the FSM encoding, access-size codes and the alignment check.
package dm_lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Access attributes captured when a request is accepted.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sext;
    logic [1:0] off;
  } acc_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = off[0];
      SZ_W:    misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// CPU-side access bus and word-memory port of the load/store unit.
// master = CPU datapath plus memory, slave = the load/store unit.
interface dm_lsu_if #(parameter int ADDR_W = 10);

  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sext;
  logic [31:0]       vaddr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;
  logic              misalign;
  logic              busy;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_din;
  logic              dm_we;
  logic [31:0]       dm_dout;

  modport master (
    output req, we, size, sext, vaddr, wdata, dm_dout,
    input  rdata, ack, misalign, busy, dm_addr, dm_din, dm_we
  );

  modport slave (
    input  req, we, size, sext, vaddr, wdata, dm_dout,
    output rdata, ack, misalign, busy, dm_addr, dm_din, dm_we
  );

endinterface

// File: rtl/dm_lsu_lane.sv
// Byte-lane steering: merges store data into a word and extracts/extends load data.
// Purely combinational, zero latency, no backpressure.
module dm_lsu_lane
  import dm_lsu_pkg::*;
(
  input  logic [31:0] wbuf,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_word,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sext,
  output logic [31:0] merged,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  always_comb begin
    merged = wbuf;
    case (size)
      SZ_B: begin
        case (off)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (off[1]) merged[31:16] = wdata[15:0];
        else        merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

  always_comb begin
    case (off)
      2'd0:    ld_b = rd_word[7:0];
      2'd1:    ld_b = rd_word[15:8];
      2'd2:    ld_b = rd_word[23:16];
      default: ld_b = rd_word[31:24];
    endcase
    ld_h = off[1] ? rd_word[31:16] : rd_word[15:0];
    case (size)
      SZ_B:    ld_data = {{24{sext & ld_b[7]}}, ld_b};
      SZ_H:    ld_data = {{16{sext & ld_h[15]}}, ld_h};
      default: ld_data = rd_word;
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit for a word-wide data memory; sub-word stores are read-modify-write.
// ack after 1 (reject), 2 (load/word store) or 3 (sub-word store) cycles; req ignored while busy.
module dm_lsu
  import dm_lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input logic       clk,
  input logic       rst_n,
  dm_lsu_if.slave   bus
);

  state_t            state;
  acc_t              acc;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdat_q;
  logic [31:0]       wbuf;
  logic [31:0]       rdata_q;
  logic [31:0]       merged;
  logic [31:0]       ld_data;
  logic              unused_vaddr;

  assign unused_vaddr = ^bus.vaddr[31:ADDR_W+2];

  dm_lsu_lane u_lane (
    .wbuf    (wbuf),
    .wdata   (wdat_q),
    .rd_word (bus.dm_dout),
    .size    (acc.size),
    .off     (acc.off),
    .sext    (acc.sext),
    .merged  (merged),
    .ld_data (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      waddr   <= '0;
      wdat_q  <= '0;
      wbuf    <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            acc.we   <= bus.we;
            acc.size <= bus.size;
            acc.sext <= bus.sext;
            acc.off  <= bus.vaddr[1:0];
            waddr    <= bus.vaddr[ADDR_W+1:2];
            wdat_q   <= bus.wdata;
            if (misaligned(bus.size, bus.vaddr[1:0]))
              state <= ST_ERR;
            else if (bus.we && bus.size == SZ_W)
              state <= ST_WRITE;
            else
              state <= ST_READ;
          end
        end
        ST_READ: begin
          wbuf <= bus.dm_dout;
          // Loads capture the result here so rdata is valid throughout RESP.
          if (acc.we) begin
            state <= ST_WRITE;
          end else begin
            rdata_q <= ld_data;
            state   <= ST_RESP;
          end
        end
        ST_WRITE: state <= ST_RESP;
        ST_RESP:  state <= ST_IDLE;
        ST_ERR:   state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are pure state decodes so they drop with the async reset.
  assign bus.ack      = (state == ST_RESP) || (state == ST_ERR);
  assign bus.misalign = (state == ST_ERR);
  assign bus.busy     = (state != ST_IDLE);
  assign bus.dm_we    = (state == ST_WRITE);
  assign bus.dm_addr  = waddr;
  assign bus.dm_din   = merged;
  assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu against a small word-memory model.
module tb_dm_lsu;
  import dm_lsu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_lsu_if #(.ADDR_W(10)) bus();

  dm_lsu #(.ADDR_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [0:1023];
  logic        preload = 1'b0;

  assign bus.dm_dout = mem[bus.dm_addr];

  always @(posedge clk) begin
    if (preload) begin
      mem[1] <= 32'h8899AABB;
      mem[2] <= 32'h0;
    end else if (bus.dm_we) begin
      mem[bus.dm_addr] <= bus.dm_din;
    end
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  int   ack_cyc, n_ack, n_we;
  logic mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_preload();
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
  endtask

  // Issue one access and watch 8 cycles; poke re-raises req during the busy window.
  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d, input bit poke);
    @(negedge clk);
    bus.we    = w;
    bus.size  = sz;
    bus.sext  = sx;
    bus.vaddr = a;
    bus.wdata = d;
    bus.req   = 1'b1;
    @(posedge clk);
    ack_cyc = 0;
    n_ack   = 0;
    n_we    = 0;
    mis     = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) bus.req = 1'b0;
      if (c == 2) bus.req = poke;
      if (c == 3) bus.req = 1'b0;
      if (bus.dm_we) n_we++;
      if (bus.ack) begin
        n_ack++;
        if (ack_cyc == 0) begin
          ack_cyc = c;
          mis     = bus.misalign;
        end
      end
    end
  endtask

  task automatic check_acc(input string tag, input int exp_cyc, input int exp_we, input logic exp_mis);
    check({tag, ".ack_cyc"}, ack_cyc, exp_cyc);
    check({tag, ".n_ack"}, n_ack, 1);
    check({tag, ".n_we"}, n_we, exp_we);
    check({tag, ".misalign"}, {31'b0, mis}, {31'b0, exp_mis});
  endtask

  initial begin
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.size  = SZ_W;
    bus.sext  = 1'b0;
    bus.vaddr = '0;
    bus.wdata = '0;
    repeat (2) @(negedge clk);
    check("rst.rdata", bus.rdata, 32'h0);
    check("rst.ack", {31'b0, bus.ack}, 32'h0);
    check("rst.misalign", {31'b0, bus.misalign}, 32'h0);
    check("rst.busy", {31'b0, bus.busy}, 32'h0);
    check("rst.dm_we", {31'b0, bus.dm_we}, 32'h0);
    check("rst.dm_addr", {22'b0, bus.dm_addr}, 32'h0);
    check("rst.dm_din", bus.dm_din, 32'h0);
    rst_n = 1'b1;

    do_preload();
    access(1'b0, SZ_B, 1'b1, 32'h006, 32'h0, 1'b0);
    check("lb.rdata", bus.rdata, 32'hFFFFFF99);
    check_acc("lb", 2, 0, 1'b0);
    access(1'b0, SZ_B, 1'b0, 32'h006, 32'h0, 1'b0);
    check("lbu.rdata", bus.rdata, 32'h00000099);
    check_acc("lbu", 2, 0, 1'b0);
    access(1'b0, SZ_H, 1'b1, 32'h006, 32'h0, 1'b0);
    check("lh.rdata", bus.rdata, 32'hFFFF8899);
    check_acc("lh", 2, 0, 1'b0);
    access(1'b0, SZ_H, 1'b0, 32'h004, 32'h0, 1'b0);
    check("lhu.rdata", bus.rdata, 32'h0000AABB);
    access(1'b0, SZ_W, 1'b1, 32'h004, 32'h0, 1'b0);
    check("lw.rdata", bus.rdata, 32'h8899AABB);
    check_acc("lw", 2, 0, 1'b0);

    do_preload();
    access(1'b1, SZ_B, 1'b0, 32'h005, 32'h12345677, 1'b0);
    check("sb.mem1", mem[1], 32'h889977BB);
    check_acc("sb", 3, 1, 1'b0);
    access(1'b1, SZ_H, 1'b0, 32'h006, 32'h0000CAFE, 1'b0);
    check("sh.mem1", mem[1], 32'hCAFE77BB);
    check_acc("sh", 3, 1, 1'b0);

    do_preload();
    access(1'b1, SZ_W, 1'b0, 32'h008, 32'hDEADBEEF, 1'b1);
    check("sw.mem2", mem[2], 32'hDEADBEEF);
    check("sw.mem1", mem[1], 32'h8899AABB);
    check_acc("sw_poke", 2, 1, 1'b0);

    do_preload();
    access(1'b0, SZ_W, 1'b0, 32'h006, 32'h0, 1'b0);
    check_acc("err_lw", 1, 0, 1'b1);
    access(1'b1, SZ_H, 1'b0, 32'h005, 32'hFFFFFFFF, 1'b0);
    check_acc("err_sh", 1, 0, 1'b1);
    access(1'b1, 2'b11, 1'b0, 32'h004, 32'hFFFFFFFF, 1'b0);
    check_acc("err_sz", 1, 0, 1'b1);
    check("err.mem1", mem[1], 32'h8899AABB);
    check("err.mem2", mem[2], 32'h0);

    do_preload();
    @(negedge clk);
    bus.we    = 1'b1;
    bus.size  = SZ_B;
    bus.sext  = 1'b0;
    bus.vaddr = 32'h004;
    bus.wdata = 32'h00000055;
    bus.req   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    check("rst_mid.we_before", {31'b0, bus.dm_we}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.we_async", {31'b0, bus.dm_we}, 32'h0);
    check("rst_mid.busy_async", {31'b0, bus.busy}, 32'h0);
    n_ack = 0;
    @(negedge clk);
    if (bus.ack) n_ack++;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.ack) n_ack++;
    end
    check("rst_mid.n_ack", n_ack, 0);
    check("rst_mid.mem1", mem[1], 32'h8899AABB);
    check("rst_mid.busy", {31'b0, bus.busy}, 32'h0);
    check("rst_mid.rdata", bus.rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
